// File: rtl/lc_pkg.sv
// lc_pkg: shared types and constants for the little_computer program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the S_CSUM state and a
// trailing XOR checksum byte to the image format).
package lc_pkg;

    // Image framing: a big-endian word count followed by big-endian words.
    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 2;
    localparam int LEN_W      = LEN_BYTES * 8;
    localparam int WORD_W     = WORD_BYTES * 8;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_CSUM, S_DONE, S_ERR
    } loader_state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_DONE, S_ERR
    } loader_state_t;
`endif

    // UART receiver frame states.
    typedef enum logic [1:0] {
        R_IDLE, R_START, R_DATA, R_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: memory write port between the program loader and
// the SDRAM controller.
//
// Handshake: the master raises mem_valid with mem_addr/mem_wdata and holds
// all three stable until a rising clk edge where mem_valid && mem_ready;
// that edge is the transfer. The slave may drive mem_ready at any time and
// mem_ready has no meaning while mem_valid is low.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 16
);
    import lc_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_valid;
    logic              mem_ready;

    modport master (output mem_addr, output mem_wdata, output mem_valid, input mem_ready);
    modport slave  (input mem_addr, input mem_wdata, input mem_valid, output mem_ready);

endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver. Emits one-cycle rx_valid pulses for
// good frames and one-cycle rx_ferr pulses when the stop bit samples low.
module uart_rx
    import lc_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    output logic [7:0] rx_data,
    output logic      rx_valid,
    output logic      rx_ferr,
    output rx_state_t dbg_state
);

    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;

    assign dbg_state = state;

    // Two-flop synchronizer plus one history flop for start-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Frame receiver: mid-bit sampling, data shifted in LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= R_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        cnt   <= CNT_W'(HALF_CYC - 1);
                        state <= R_START;
                    end
                end
                R_START: begin
                    if (cnt == '0) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (!rx_sync) begin
                            cnt     <= CNT_W'(BIT_CYC - 1);
                            bit_idx <= '0;
                            state   <= R_DATA;
                        end else begin
                            state <= R_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == '0) begin
                        rx_data <= {rx_sync, rx_data[7:1]};
                        cnt     <= CNT_W'(BIT_CYC - 1);
                        if (bit_idx == 3'd7) state <= R_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == '0) begin
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                        state    <= R_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: boot-time loader that receives a length-prefixed program
// image over UART and writes it to memory from word address 0 upward.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module uart_prog_loader
    import lc_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    uart_prog_loader_if.master   mem,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W-1:0]    words_loaded,
    output loader_state_t        dbg_state,
    output rx_state_t            dbg_rx_state
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    loader_state_t    state;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ferr;
    logic [7:0]       hi_byte;   // LEN_HI, then each word's HI byte
    logic [LEN_W-1:0] remain;    // words still to be accepted
    logic [TMO_W-1:0] tmo_cnt;   // idle cycles since the last byte
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum;      // XOR of every image byte so far
`endif

    assign dbg_state = state;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ferr   (rx_ferr),
        .dbg_state (dbg_rx_state)
    );

    // Loader FSM: byte parsing, write issue, timeout and error tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            words_loaded  <= '0;
            mem.mem_valid <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            hi_byte       <= '0;
            remain        <= '0;
            tmo_cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        hi_byte      <= rx_data;
                        words_loaded <= '0;
                        tmo_cnt      <= '0;
                        busy         <= 1'b1;
                        state        <= S_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= rx_data;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM: begin
`else
                S_LEN_LO, S_DATA_HI, S_DATA_LO: begin
`endif
                    if (rx_ferr) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (rx_valid) begin
                        tmo_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ rx_data;
`endif
                        case (state)
                            S_LEN_LO: begin
                                remain <= {hi_byte, rx_data};
                                if ({hi_byte, rx_data} == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                    state <= S_CSUM;
`else
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
`endif
                                end else begin
                                    state <= S_DATA_HI;
                                end
                            end
                            S_DATA_HI: begin
                                hi_byte <= rx_data;
                                state   <= S_DATA_LO;
                            end
                            S_DATA_LO: begin
                                mem.mem_addr  <= words_loaded;
                                mem.mem_wdata <= {hi_byte, rx_data};
                                mem.mem_valid <= 1'b1;
                                state         <= S_WRITE;
                            end
                            default: begin
`ifdef LOADER_CHECKSUM_EN
                                // Checksum byte: compared against all earlier bytes.
                                busy <= 1'b0;
                                if (rx_data == csum) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_ERR;
                                    err   <= 1'b1;
                                end
`endif
                            end
                        endcase
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    // Timeout counter holds here; a new byte is an overrun.
                    if (rx_valid || rx_ferr) begin
                        state         <= S_ERR;
                        err           <= 1'b1;
                        busy          <= 1'b0;
                        mem.mem_valid <= 1'b0;
                    end else if (mem.mem_ready) begin
                        mem.mem_valid <= 1'b0;
                        words_loaded  <= words_loaded + 1'b1;
                        remain        <= remain - 1'b1;
                        if (remain == LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`endif
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    err           <= 1'b1;
                    busy          <= 1'b0;
                    mem.mem_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed and randomized image loads through the UART
// line, checked against a queue of expected memory writes.
// Optional feature macro: LOADER_CHECKSUM_EN (bench appends checksum bytes).
module tb_uart_prog_loader;
    import lc_pkg::*;

    localparam int CLK_HZ      = 1600;
    localparam int BAUD        = 100;
    localparam int ADDR_W      = 16;
    localparam int TIMEOUT_CYC = 2000;
    localparam int BIT_CYC     = CLK_HZ / BAUD;
    localparam int W           = ADDR_W + 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              uart_rx;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] words_loaded;
    loader_state_t     dbg_state;
    rx_state_t         dbg_rx_state;

    uart_prog_loader_if #(.ADDR_W(ADDR_W)) mem_if ();

    uart_prog_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .mem          (mem_if),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state),
        .dbg_rx_state (dbg_rx_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q[$];
    logic [15:0]   words[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            wr_cnt      = 0;
    int            done_cnt    = 0;
    int            ready_mode  = 0;  // 0 always, 1 stall 20, 2 random, 3 never
    int            stall_cnt   = 0;
    logic              prev_stall = 1'b0;
    logic              prev_done  = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [15:0]       prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(BIT_CYC);
        end
        uart_rx = stop_bit;
        tick(BIT_CYC);
        uart_rx = 1'b1;
        tick(BIT_CYC);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        uart_rx = 1'b1;
        tick(BIT_CYC);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(mem_if.mem_valid), 0);
        check({tag, "_addr"},  32'(mem_if.mem_addr), 0);
        check({tag, "_wdata"}, 32'(mem_if.mem_wdata), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_err"},   32'(err), 0);
        check({tag, "_wl"},    32'(words_loaded), 0);
    endtask

    // Reference model: image bytes and expected writes built from the word list.
    task automatic run_load(input int n, input string tag);
        logic [7:0]  img[$];
        logic [7:0]  x;
        logic [15:0] nn;
        int          d0;
        int          w0;
        nn = 16'(n);
        img.push_back(nn[15:8]);
        img.push_back(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            img.push_back(words[i][15:8]);
            img.push_back(words[i][7:0]);
            exp_q.push_back({ADDR_W'(i), words[i]});
        end
`ifdef LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (img[i]) x = x ^ img[i];
        img.push_back(x);
`else
        x = 8'h00;
`endif
        d0 = done_cnt;
        w0 = wr_cnt;
        foreach (img[i]) begin
            send_byte(img[i], 1'b1);
            if (i == 0) check({tag, "_busy_start"}, 32'(busy), 1);
        end
        for (int i = 0; i < 400 && done_cnt == d0; i++) tick(1);
        check({tag, "_done_cnt"}, done_cnt, d0 + 1);
        check({tag, "_wr_cnt"}, wr_cnt, w0 + n);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(ADDR_W'(n)));
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_busy_end"}, 32'(busy), 0);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_valid_end"}, 32'(mem_if.mem_valid), 0);
    endtask

    // ---------------- memory-side responder ----------------
    initial begin
        mem_if.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 0) begin
                mem_if.mem_ready = 1'b1;
            end else if (ready_mode == 1) begin
                if (mem_if.mem_valid && stall_cnt >= 20) begin
                    mem_if.mem_ready = 1'b1;
                    stall_cnt = 0;
                end else if (mem_if.mem_valid) begin
                    mem_if.mem_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_if.mem_ready = 1'b0;
                    stall_cnt = 0;
                end
            end else if (ready_mode == 2) begin
                mem_if.mem_ready = 1'($urandom_range(0, 1));
            end else begin
                mem_if.mem_ready = 1'b0;
            end
        end
    end

    // ---------------- write / done monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(mem_if.mem_valid), 1);
                check("stall_addr", 32'(mem_if.mem_addr), 32'(prev_addr));
                check("stall_data", 32'(mem_if.mem_wdata), 32'(prev_data));
            end
            if (done) begin
                done_cnt++;
                check("done_width", 32'(prev_done), 0);
            end
            if (mem_if.mem_valid && mem_if.mem_ready) begin
                wr_cnt++;
                check("wr_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_if.mem_addr), 32'(e[W-1:16]));
                    check("wr_data", 32'(mem_if.mem_wdata), 32'(e[15:0]));
                end
            end
            prev_stall = mem_if.mem_valid && !mem_if.mem_ready;
            prev_addr  = mem_if.mem_addr;
            prev_data  = mem_if.mem_wdata;
            prev_done  = done;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int w0;
        int n;
        uart_rx = 1'b1;
        rst     = 1'b1;
        tick(3);
        check_idle("reset");
        check("reset_state", 32'(dbg_state), 32'(S_IDLE));
        check("reset_rx_state", 32'(dbg_rx_state), 32'(R_IDLE));
        rst = 1'b0;
        tick(BIT_CYC);

        // Single word, memory always ready.
        ready_mode = 0;
        words = '{16'hE000};
        run_load(1, "t1");

        // Six words with a 20-cycle stall on every write.
        ready_mode = 1;
        words = '{16'h1001, 16'h2202, 16'h3403, 16'h4804, 16'h5F05, 16'hA0A6};
        run_load(6, "t2");

        // Empty image.
        ready_mode = 0;
        words.delete();
        run_load(0, "t3");

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum on an empty image.
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        tick(4);
        check("csum_bad_err", 32'(err), 1);
        check("csum_bad_busy", 32'(busy), 0);
        do_reset();
`endif

        // Frame error during the data phase, then recovery after reset.
        w0 = wr_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        tick(4);
        check("ferr_err", 32'(err), 1);
        check("ferr_busy", 32'(busy), 0);
        check("ferr_valid", 32'(mem_if.mem_valid), 0);
        check("ferr_state", 32'(dbg_state), 32'(S_ERR));
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        check("ferr_no_write", wr_cnt, w0);
        check("ferr_sticky", 32'(err), 1);
        do_reset();
        check_idle("ferr_rst");
        words = '{16'h1234};
        run_load(1, "t4");

        // Inter-byte timeout.
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAB, 1'b1);
        tick(TIMEOUT_CYC / 2);
        check("tmo_early_err", 32'(err), 0);
        check("tmo_early_busy", 32'(busy), 1);
        tick(TIMEOUT_CYC / 2 + 10);
        check("tmo_err", 32'(err), 1);
        check("tmo_busy", 32'(busy), 0);
        do_reset();

        // Asynchronous reset with a write pending and a frame in flight.
        ready_mode = 3;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("pend_valid", 32'(mem_if.mem_valid), 1);
        check("pend_addr", 32'(mem_if.mem_addr), 0);
        check("pend_data", 32'(mem_if.mem_wdata), 32'h1122);
        uart_rx = 1'b0;
        tick(3 * BIT_CYC);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        tick(2);
        uart_rx = 1'b1;
        rst = 1'b0;
        tick(2 * BIT_CYC);
        ready_mode = 2;
        words = '{16'($urandom), 16'($urandom)};
        run_load(2, "t6");

        // Randomized images with random memory back-pressure.
        repeat (4) begin
            n = int'($urandom_range(1, 5));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            run_load(n, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
